// File: rtl/booth_controller.sv
// booth_controller: sequencing FSM for a radix-2 Booth multiplier datapath.
// Issues load/enable strobes to the operand registers, clears the accumulator,
// then alternates WIDTH evaluate/shift iterations and pulses done.
//
// Ports:
//   i_clk             rising-edge clock
//   i_reset           asynchronous active-high reset
//   i_start           request a multiplication (sampled in IDLE only)
//   i_abort           synchronous cancel, honoured in any non-IDLE state
//   i_q0, i_qm1       multiplier LSB and Booth extra bit Q(-1)
//   o_ld_a, o_ld_b    operand register load strobes
//   o_en_a, o_en_b    operand register output enables
//   o_clr_acc         clear accumulator and Q(-1)
//   o_add, o_sub      accumulator +=/-= multiplicand (EVAL only, combinational)
//   o_shift           arithmetic right shift of {acc, Q, Q(-1)}
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse when the product is valid
//   o_iter            remaining iterations
module booth_controller #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_q0,
  input  logic          i_qm1,
  output logic          o_ld_a,
  output logic          o_ld_b,
  output logic          o_en_a,
  output logic          o_en_b,
  output logic          o_clr_acc,
  output logic          o_add,
  output logic          o_sub,
  output logic          o_shift,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_INIT,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_ld;
  logic          r_en;
  logic          r_clr;
  logic          r_shift;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_iter;
  logic          w_eval;

  // State and Moore outputs: each transition registers the strobes of the
  // state being entered, so the strobes line up exactly with the state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ld    <= 1'b0;
      r_en    <= 1'b0;
      r_clr   <= 1'b0;
      r_shift <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_iter  <= '0;
    end else begin
      r_ld    <= 1'b0;
      r_en    <= 1'b0;
      r_clr   <= 1'b0;
      r_shift <= 1'b0;
      r_done  <= 1'b0;
      // abort outranks every other transition, including SHIFT->DONE
      if (r_state != S_IDLE && i_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_iter  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_LOAD;
              r_ld    <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state <= S_XFER;
            r_en    <= 1'b1;
          end
          S_XFER: begin
            r_state <= S_INIT;
            r_clr   <= 1'b1;
          end
          S_INIT: begin
            r_state <= S_EVAL;
            r_iter  <= CW'(WIDTH);
          end
          S_EVAL: begin
            r_state <= S_SHIFT;
            r_shift <= 1'b1;
          end
          S_SHIFT: begin
            r_iter <= r_iter - CW'(1);
            if (r_iter == CW'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_EVAL;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Booth recoding of {q0, qm1}: 10 -> subtract, 01 -> add, else neither
  assign w_eval = (r_state == S_EVAL);
  assign o_sub  = w_eval &  i_q0 & ~i_qm1;
  assign o_add  = w_eval & ~i_q0 &  i_qm1;

  assign o_ld_a    = r_ld;
  assign o_ld_b    = r_ld;
  assign o_en_a    = r_en;
  assign o_en_b    = r_en;
  assign o_clr_acc = r_clr;
  assign o_shift   = r_shift;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_iter    = r_iter;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: scoreboard bench for booth_controller (WIDTH=16).
// Stimulus pushes the hand-derived per-cycle output pattern of each operation
// into a queue; the monitor pops and compares every cycle the DUT is busy or
// strobing.
module tb_booth_controller;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_q0 = 1'b0;
  logic          i_qm1 = 1'b0;
  logic          o_ld_a, o_ld_b, o_en_a, o_en_b, o_clr_acc;
  logic          o_add, o_sub, o_shift, o_busy, o_done;
  logic [CW-1:0] o_iter;

  booth_controller #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_q0(i_q0), .i_qm1(i_qm1),
    .o_ld_a(o_ld_a), .o_ld_b(o_ld_b), .o_en_a(o_en_a), .o_en_b(o_en_b),
    .o_clr_acc(o_clr_acc), .o_add(o_add), .o_sub(o_sub), .o_shift(o_shift),
    .o_busy(o_busy), .o_done(o_done), .o_iter(o_iter)
  );

  always #5 clk = ~clk;

  // vec bit order: {ld_a, ld_b, en_a, en_b, clr, add, sub, shift, done, busy}
  localparam logic [9:0] V_LOAD  = 10'b11_00_0_0_0_0_0_1;
  localparam logic [9:0] V_XFER  = 10'b00_11_0_0_0_0_0_1;
  localparam logic [9:0] V_INIT  = 10'b00_00_1_0_0_0_0_1;
  localparam logic [9:0] V_EVAL  = 10'b00_00_0_0_0_0_0_1;
  localparam logic [9:0] V_ADD   = 10'b00_00_0_1_0_0_0_0;
  localparam logic [9:0] V_SUB   = 10'b00_00_0_0_1_0_0_0;
  localparam logic [9:0] V_SHIFT = 10'b00_00_0_0_0_1_0_1;
  localparam logic [9:0] V_DONE  = 10'b00_00_0_0_0_0_1_1;

  typedef struct packed {
    int unsigned cyc;
    logic [9:0]  vec;
    logic [4:0]  iter;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  // bench model of the multiplier shift register
  logic        model_en = 1'b0;
  logic [15:0] mult = 16'h0000;
  logic [15:0] mq = 16'h0000;
  logic        mqm1 = 1'b0;
  logic        fix_q0 = 1'b0;
  logic        fix_qm1 = 1'b0;
  logic        m_clr, m_sh;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] outs();
    return {o_ld_a, o_ld_b, o_en_a, o_en_b, o_clr_acc, o_add, o_sub, o_shift, o_done, o_busy};
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input int unsigned c, input logic [9:0] v, input logic [4:0] it,
                         input int unsigned last);
    ev_t e;
    if (c <= last) begin
      e.cyc  = c;
      e.vec  = v;
      e.iter = it;
      exp_q.push_back(e);
    end
  endtask

  // Expected sequence of one operation whose LOAD cycle is ld; events after
  // cycle 'last' are dropped (abort/reset cases).
  task automatic push_op(input int unsigned ld, input logic [15:0] subm,
                         input logic [15:0] addm, input int unsigned last);
    logic [9:0] v;
    push_if(ld,     V_LOAD, 5'd0, last);
    push_if(ld + 1, V_XFER, 5'd0, last);
    push_if(ld + 2, V_INIT, 5'd0, last);
    for (int k = 1; k <= 16; k++) begin
      v = V_EVAL | (subm[k-1] ? V_SUB : 10'd0) | (addm[k-1] ? V_ADD : 10'd0);
      push_if(ld + 3 + 2 * (k - 1), v,       5'(17 - k), last);
      push_if(ld + 4 + 2 * (k - 1), V_SHIFT, 5'(17 - k), last);
    end
    push_if(ld + 35, V_DONE, 5'd0, last);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      next_cyc();
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) next_cyc();
  endtask

  // Monitor: every cycle with busy or any strobe high is one scoreboard event
  logic [9:0] mon_v;
  ev_t        mon_e;
  always @(negedge clk) begin
    mon_v = outs();
    if (mon_v != 10'd0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: cyc=%0d vec=%b iter=%0d required no activity",
                 cyc, mon_v, o_iter);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec != mon_v || mon_e.iter != o_iter) begin
          bad++;
          $display("FAIL event: got cyc=%0d vec=%b iter=%0d required cyc=%0d vec=%b iter=%0d",
                   cyc, mon_v, o_iter, mon_e.cyc, mon_e.vec, mon_e.iter);
        end
      end
    end
  end

  // Drives q0/qm1: from the shift model (updated after clr/shift edges) or fixed
  initial begin
    forever begin
      @(negedge clk);
      m_clr = o_clr_acc;
      m_sh  = o_shift;
      @(posedge clk);
      #1;
      if (model_en) begin
        if (m_clr) begin
          mq   = mult;
          mqm1 = 1'b0;
        end else if (m_sh) begin
          mqm1 = mq[0];
          mq   = {mq[15], mq[15:1]};
        end
        i_q0  = mq[0];
        i_qm1 = mqm1;
      end else begin
        i_q0  = fix_q0;
        i_qm1 = fix_qm1;
      end
    end
  end

  initial begin
    int unsigned b;

    // async reset mid-cycle, before any clock edge
    #2 i_reset = 1'b1;
    #1;
    check("reset_outputs", 32'(outs()), 0);
    check("reset_iter", 32'(o_iter), 0);
    next_cyc();
    next_cyc();
    i_reset = 1'b0;

    // idle with start low (abort in IDLE must do nothing)
    i_abort = 1'b1;
    repeat (10) next_cyc();
    i_abort = 1'b0;
    check("idle_busy", 32'(o_busy), 0);
    check("idle_iter", 32'(o_iter), 0);

    // nominal all-sub, start ignored at 5/20/36, held from 36 -> LOAD at 38
    fix_q0 = 1'b1; fix_qm1 = 1'b0;
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    push_op(b + 1,  16'hFFFF, 16'h0000, 32'hFFFF_FFFF);
    push_op(b + 38, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF);
    for (int r = 1; r <= 38; r++) begin
      next_cyc();
      i_start = (r == 5 || r == 20 || r == 36 || r == 37);
    end
    wait_drain("nominal");

    // Booth pattern for multiplier 0x00F0: sub at iteration 5, add at 9
    mult = 16'h00F0;
    model_en = 1'b1;
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    push_op(b + 1, 16'h0010, 16'h0100, 32'hFFFF_FFFF);
    next_cyc();
    i_start = 1'b0;
    wait_drain("booth");
    model_en = 1'b0;

    // abort in cycle 12 (EVAL), all-add pattern
    fix_q0 = 1'b0; fix_qm1 = 1'b1;
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    push_op(b + 1, 16'h0000, 16'hFFFF, b + 12);
    for (int r = 1; r <= 12; r++) begin
      next_cyc();
      i_start = 1'b0;
      i_abort = (r == 12);
    end
    next_cyc();
    i_abort = 1'b0;
    check("abort12_busy", 32'(o_busy), 0);
    check("abort12_iter", 32'(o_iter), 0);
    check("abort12_done", 32'(o_done), 0);
    wait_drain("abort12");

    // abort in cycle 35 (last SHIFT) must suppress done
    fix_q0 = 1'b1; fix_qm1 = 1'b1;
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    push_op(b + 1, 16'h0000, 16'h0000, b + 35);
    for (int r = 1; r <= 35; r++) begin
      next_cyc();
      i_start = 1'b0;
      i_abort = (r == 35);
    end
    next_cyc();
    i_abort = 1'b0;
    check("abort35_done", 32'(o_done), 0);
    check("abort35_iter", 32'(o_iter), 0);
    wait_drain("abort35");

    // start and abort together in IDLE -> LOAD
    fix_q0 = 1'b0; fix_qm1 = 1'b0;
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    i_abort = 1'b1;
    push_op(b + 1, 16'h0000, 16'h0000, 32'hFFFF_FFFF);
    next_cyc();
    i_start = 1'b0;
    i_abort = 1'b0;
    wait_drain("start_abort");

    // async reset during cycle 21, a SHIFT cycle
    fix_q0 = 1'b1; fix_qm1 = 1'b0;
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    push_op(b + 1, 16'hFFFF, 16'h0000, b + 21);
    for (int r = 1; r <= 21; r++) begin
      next_cyc();
      i_start = 1'b0;
    end
    check("pre_reset_shift", 32'(o_shift), 1);
    #6 i_reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 0);
    check("async_reset_iter", 32'(o_iter), 0);
    next_cyc();
    next_cyc();
    i_reset = 1'b0;
    check("post_reset_queue", exp_q.size(), 0);
    exp_q.delete();
    next_cyc();
    b = cyc;
    i_start = 1'b1;
    push_op(b + 1, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF);
    next_cyc();
    i_start = 1'b0;
    wait_drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
